// File: rtl/motion_pkg.sv
// motion_pkg: shared types and constants for the motion sequencer.
//   cmd_e   - remote command codes as delivered by the IR decoder
//   state_e - sequencer FSM states
//   VEL_MAX - magnitude limit of the signed target velocity
package motion_pkg;

  typedef enum logic [2:0] {
    CMD_ON    = 3'd0,
    CMD_OFF   = 3'd1,
    CMD_FWD   = 3'd2,
    CMD_BWD   = 3'd3,
    CMD_LEFT  = 3'd4,
    CMD_RIGHT = 3'd5,
    CMD_STOP  = 3'd6,
    CMD_RSVD  = 3'd7
  } cmd_e;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_RUN   = 2'd1,
    ST_BRAKE = 2'd2
  } state_e;

  localparam int VEL_MAX = 255;

endpackage

// File: rtl/tick_gen.sv
// tick_gen: divides clk down to a one-cycle tick at TICK_HZ.
//   clk   - system clock
//   rst_n - asynchronous active-low reset (divider returns to 0)
//   tick  - high for one clk each time the divider sits at DIV-1
module tick_gen #(
  parameter int CLK_HZ  = 25000000,
  parameter int TICK_HZ = 256
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int DIV = (CLK_HZ / TICK_HZ < 1) ? 1 : CLK_HZ / TICK_HZ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (count_reg == LAST) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + CW'(1);
    end
  end

  assign tick = (count_reg == LAST);

endmodule

// File: rtl/motion_sequencer.sv
// motion_sequencer: turns remote commands into a signed target velocity and a
// steering setpoint, then slews motor_dc toward the target on each tick with
// bounded acceleration, braking to zero before any direction reversal.
// Also applies an obstacle stop and a command watchdog.
//   clk, rst_n               - clock, asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd  - command stream (never backpressured)
//   obst_valid/can_move_fwd  - obstacle sensor update strobe and value
//   motor_dc, direction      - speed magnitude and sign (1 = forward)
//   servo_dc                 - steering duty cycle
//   ctl_valid                - pulses with every change of the three outputs
//   running                  - state is not OFF
module motion_sequencer
  import motion_pkg::*;
#(
  parameter int CLK_HZ        = 25000000,
  parameter int TICK_HZ       = 256,
  parameter int SPEED_STEP    = 8,
  parameter int ACCEL         = 1,
  parameter int SERVO_STEP    = 4,
  parameter int SERVO_MIN     = 64,
  parameter int SERVO_CTR     = 128,
  parameter int SERVO_MAX     = 192,
  parameter int TIMEOUT_TICKS = 128
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd,
  input  logic       obst_valid,
  input  logic       can_move_fwd,
  output logic [7:0] motor_dc,
  output logic       direction,
  output logic [7:0] servo_dc,
  output logic       ctl_valid,
  output logic       running
);

  localparam logic [7:0]        ACCEL_B    = 8'(ACCEL);
  localparam logic [7:0]        SSTEP_B    = 8'(SERVO_STEP);
  localparam logic [7:0]        SMIN_B     = 8'(SERVO_MIN);
  localparam logic [7:0]        SCTR_B     = 8'(SERVO_CTR);
  localparam logic [7:0]        SMAX_B     = 8'(SERVO_MAX);
  localparam logic [8:0]        SSTEP_W    = 9'(SERVO_STEP);
  localparam logic [8:0]        SMIN_W     = 9'(SERVO_MIN);
  localparam logic [8:0]        SMAX_W     = 9'(SERVO_MAX);
  localparam logic signed [9:0] VSTEP_W    = 10'(SPEED_STEP);
  localparam logic signed [9:0] VMAX_W     = 10'(VEL_MAX);
  localparam logic signed [8:0] VMAX_T     = 9'(VEL_MAX);
  localparam int                WW         = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [WW-1:0]     WD_LIMIT   = WW'(TIMEOUT_TICKS);

  logic tick;

  tick_gen #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  state_e              state_reg, state_next;
  logic [7:0]          motor_reg, motor_next;
  logic                dir_reg, dir_next;
  logic [7:0]          servo_reg, servo_next;
  logic signed [8:0]   tv_reg, tv_next;
  logic [WW-1:0]       wdog_reg, wdog_next;
  logic                clear_reg, clear_next;  // latched can_move_fwd
  logic                ctl_reg, ctl_next;

  logic                cmd_fire;
  logic [7:0]          tv_mag;
  logic                tv_dir;
  logic                tv_match;
  logic signed [9:0]   tv_up, tv_dn;
  logic signed [8:0]   tv_fwd, tv_bwd;

  assign cmd_ready = rst_n;
  assign cmd_fire  = cmd_valid && cmd_ready;

  // Sign/magnitude view of the pre-command target; zero matches either direction.
  assign tv_mag   = tv_reg[8] ? 8'(-tv_reg) : tv_reg[7:0];
  assign tv_dir   = ~tv_reg[8];
  assign tv_match = (tv_reg == '0) || (tv_dir == dir_reg);

  // Saturating target updates; forward motion is capped at 0 while blocked.
  assign tv_up = 10'(tv_reg) + VSTEP_W;
  assign tv_dn = 10'(tv_reg) - VSTEP_W;

  always_comb begin
    tv_fwd = (tv_up > VMAX_W) ? VMAX_T : tv_up[8:0];
    if (!clear_reg && tv_fwd > 9'sd0) begin
      tv_fwd = '0;
    end
    tv_bwd = (tv_dn < -VMAX_W) ? -VMAX_T : tv_dn[8:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_OFF;
      motor_reg <= '0;
      dir_reg   <= 1'b1;
      servo_reg <= SCTR_B;
      tv_reg    <= '0;
      wdog_reg  <= '0;
      clear_reg <= 1'b1;
      ctl_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      motor_reg <= motor_next;
      dir_reg   <= dir_next;
      servo_reg <= servo_next;
      tv_reg    <= tv_next;
      wdog_reg  <= wdog_next;
      clear_reg <= clear_next;
      ctl_reg   <= ctl_next;
    end
  end

  // Priority: tick ramp (on pre-command values), then command, then obstacle.
  always_comb begin
    state_next = state_reg;
    motor_next = motor_reg;
    dir_next   = dir_reg;
    servo_next = servo_reg;
    tv_next    = tv_reg;
    wdog_next  = wdog_reg;
    clear_next = clear_reg;

    if (tick && state_reg != ST_OFF) begin
      if (state_reg == ST_RUN) begin
        if (tv_match) begin
          if (motor_reg < tv_mag) begin
            motor_next = (tv_mag - motor_reg > ACCEL_B) ? motor_reg + ACCEL_B : tv_mag;
          end else if (motor_reg > tv_mag) begin
            motor_next = (motor_reg - tv_mag > ACCEL_B) ? motor_reg - ACCEL_B : tv_mag;
          end
        end else if (motor_reg != '0) begin
          state_next = ST_BRAKE;
        end else begin
          // Standing still: flip now, accelerate from the next tick.
          dir_next = tv_dir;
        end
      end else begin
        if (tv_match) begin
          state_next = ST_RUN;
        end else if (motor_reg > ACCEL_B) begin
          motor_next = motor_reg - ACCEL_B;
        end else begin
          motor_next = '0;
          dir_next   = tv_dir;
          state_next = ST_RUN;
        end
      end

      // Timeout only zeroes the target; the ramp then decelerates normally.
      if (wdog_reg != WD_LIMIT) begin
        wdog_next = wdog_reg + WW'(1);
        if (wdog_reg + WW'(1) == WD_LIMIT) begin
          tv_next = '0;
        end
      end
    end

    if (cmd_fire) begin
      wdog_next = '0;
      if (state_reg == ST_OFF) begin
        if (cmd_e'(cmd) == CMD_ON) begin
          state_next = ST_RUN;
          tv_next    = '0;
          servo_next = SCTR_B;
        end
      end else begin
        case (cmd_e'(cmd))
          CMD_OFF: begin
            state_next = ST_OFF;
            motor_next = '0;
            dir_next   = dir_reg;
            tv_next    = '0;
            servo_next = SCTR_B;
          end
          CMD_STOP: begin
            state_next = ST_RUN;
            motor_next = '0;
            dir_next   = dir_reg;
            tv_next    = '0;
          end
          CMD_FWD:   tv_next = tv_fwd;
          CMD_BWD:   tv_next = tv_bwd;
          CMD_LEFT:  servo_next = ({1'b0, servo_reg} < SMIN_W + SSTEP_W) ? SMIN_B : servo_reg - SSTEP_B;
          CMD_RIGHT: servo_next = ({1'b0, servo_reg} + SSTEP_W > SMAX_W) ? SMAX_B : servo_reg + SSTEP_B;
          default: ;
        endcase
      end
    end

    if (obst_valid) begin
      clear_next = can_move_fwd;
      if (!can_move_fwd && state_next != ST_OFF) begin
        if (dir_next) begin
          motor_next = '0;
          state_next = ST_RUN;
        end
        if (tv_next > 9'sd0) begin
          tv_next = '0;
        end
      end
    end

    ctl_next = (motor_next != motor_reg) || (dir_next != dir_reg) || (servo_next != servo_reg);
  end

  assign motor_dc  = motor_reg;
  assign direction = dir_reg;
  assign servo_dc  = servo_reg;
  assign ctl_valid = ctl_reg;
  assign running   = (state_reg != ST_OFF);

endmodule

// File: tb/tb_motion_sequencer.sv
// tb_motion_sequencer: table-driven servo/ON/OFF vectors plus hand-written
// ramp, reversal, obstacle, abort and watchdog sequences. Every ctl_valid
// pulse of the main instance is checked against a queue of expected outputs.
module tb_motion_sequencer;
  import motion_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd = 3'd0;
  logic       obst_valid = 1'b0;
  logic       can_move_fwd = 1'b1;
  logic       cmd_ready, direction, ctl_valid, running;
  logic [7:0] motor_dc, servo_dc;

  logic       wd_cmd_valid = 1'b0;
  logic [2:0] wd_cmd = 3'd0;
  logic       wd_cmd_ready, wd_direction, wd_ctl_valid, wd_running;
  logic [7:0] wd_motor_dc, wd_servo_dc;

  always #5 clk = ~clk;

  motion_sequencer #(.CLK_HZ(1024), .TICK_HZ(256), .TIMEOUT_TICKS(128)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
    .obst_valid(obst_valid), .can_move_fwd(can_move_fwd), .motor_dc(motor_dc),
    .direction(direction), .servo_dc(servo_dc), .ctl_valid(ctl_valid), .running(running)
  );

  motion_sequencer #(.CLK_HZ(1024), .TICK_HZ(256), .TIMEOUT_TICKS(8)) dut_wd (
    .clk(clk), .rst_n(rst_n), .cmd_valid(wd_cmd_valid), .cmd_ready(wd_cmd_ready), .cmd(wd_cmd),
    .obst_valid(1'b0), .can_move_fwd(1'b1), .motor_dc(wd_motor_dc),
    .direction(wd_direction), .servo_dc(wd_servo_dc), .ctl_valid(wd_ctl_valid), .running(wd_running)
  );

  typedef struct { int motor; int dir; int servo; } exp_t;
  typedef struct { logic [2:0] cmd; int reps; int exp_servo; int exp_running; } vec_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic void push(input int m, input int d, input int s);
    exp_t e;
    e.motor = m; e.dir = d; e.servo = s;
    sb_q.push_back(e);
  endfunction

  // Scoreboard: each ctl_valid pulse consumes one expected output triple.
  always @(negedge clk) begin
    if (rst_n && ctl_valid) begin
      check("ctl_pulse_expected", int'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_motor", int'(motor_dc), e.motor);
        check("sb_dir", int'(direction), e.dir);
        check("sb_servo", int'(servo_dc), e.servo);
      end
    end
  end

  task automatic send(input logic [2:0] c);
    @(negedge clk); cmd_valid = 1'b1; cmd = c;
    @(negedge clk); cmd_valid = 1'b0;
  endtask

  task automatic send_wd(input logic [2:0] c);
    @(negedge clk); wd_cmd_valid = 1'b1; wd_cmd = c;
    @(negedge clk); wd_cmd_valid = 1'b0;
  endtask

  task automatic obst(input logic c);
    @(negedge clk); obst_valid = 1'b1; can_move_fwd = c;
    @(negedge clk); obst_valid = 1'b0;
  endtask

  task automatic wait_sb_empty(input int budget, input string name);
    for (int i = 0; i < budget && sb_q.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    check(name, sb_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[10];
    int servo_m, run_m, pre;
    int n_first, n_zero, first_val;

    vecs[0] = '{CMD_ON,    1,  128, 1};
    vecs[1] = '{CMD_RIGHT, 16, 192, 1};
    vecs[2] = '{CMD_RIGHT, 4,  192, 1};
    vecs[3] = '{CMD_LEFT,  1,  188, 1};
    vecs[4] = '{CMD_LEFT,  39, 64,  1};
    vecs[5] = '{CMD_RIGHT, 1,  68,  1};
    vecs[6] = '{CMD_OFF,   1,  128, 0};
    vecs[7] = '{CMD_FWD,   3,  128, 0};
    vecs[8] = '{CMD_RIGHT, 2,  128, 0};
    vecs[9] = '{CMD_ON,    1,  128, 1};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_motor", int'(motor_dc), 0);
    check("rst_dir", int'(direction), 1);
    check("rst_servo", int'(servo_dc), 128);
    check("rst_ctl", int'(ctl_valid), 0);
    check("rst_running", int'(running), 0);
    check("rst_ready", int'(cmd_ready), 0);
    rst_n = 1'b1;
    #1;
    check("ready_after_rst", int'(cmd_ready), 1);

    // Servo saturation and ON/OFF handling, table-driven
    servo_m = 128; run_m = 0;
    for (int i = 0; i < 10; i++) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        pre = servo_m;
        case (vecs[i].cmd)
          CMD_ON:    if (run_m == 0) begin run_m = 1; servo_m = 128; end
          CMD_OFF:   if (run_m == 1) begin run_m = 0; servo_m = 128; end
          CMD_LEFT:  if (run_m == 1) servo_m = (servo_m - 4 < 64) ? 64 : servo_m - 4;
          CMD_RIGHT: if (run_m == 1) servo_m = (servo_m + 4 > 192) ? 192 : servo_m + 4;
          default: ;
        endcase
        if (servo_m != pre) push(0, 1, servo_m);
        send(vecs[i].cmd);
      end
      $display("vec %0d cmd=%0d x%0d servo=%0d running=%0d motor=%0d",
               i, vecs[i].cmd, vecs[i].reps, servo_dc, running, motor_dc);
      check($sformatf("vec%0d_servo", i), int'(servo_dc), vecs[i].exp_servo);
      check($sformatf("vec%0d_running", i), int'(running), vecs[i].exp_running);
      check($sformatf("vec%0d_motor", i), int'(motor_dc), 0);
    end
    wait_sb_empty(4, "table_pulses");

    // Ramp up to 16 forward and hold
    for (int v = 1; v <= 16; v++) push(v, 1, 128);
    send(CMD_FWD); send(CMD_FWD);
    wait_sb_empty(200, "ramp_up_done");
    repeat (40) @(negedge clk);
    $display("ramp_up motor=%0d dir=%0d", motor_dc, direction);
    check("ramp_hold_motor", int'(motor_dc), 16);
    check("ramp_hold_dir", int'(direction), 1);

    // Reversal through zero
    for (int v = 15; v >= 1; v--) push(v, 1, 128);
    push(0, 0, 128);
    for (int v = 1; v <= 16; v++) push(v, 0, 128);
    send(CMD_BWD); send(CMD_BWD); send(CMD_BWD); send(CMD_BWD);
    wait_sb_empty(400, "reversal_done");
    $display("reversal motor=%0d dir=%0d", motor_dc, direction);
    check("rev_motor", int'(motor_dc), 16);
    check("rev_dir", int'(direction), 0);

    // Obstacle: get to 16 forward first
    push(0, 0, 128);
    push(0, 1, 128);
    for (int v = 1; v <= 16; v++) push(v, 1, 128);
    send(CMD_STOP); send(CMD_FWD); send(CMD_FWD);
    wait_sb_empty(200, "fwd16_done");
    push(0, 1, 128);
    obst(1'b0);
    $display("obstacle motor=%0d dir=%0d", motor_dc, direction);
    check("obst_motor", int'(motor_dc), 0);
    send(CMD_FWD);
    repeat (20) @(negedge clk);
    check("obst_fwd_blocked", int'(motor_dc), 0);
    push(0, 0, 128);
    for (int v = 1; v <= 8; v++) push(v, 0, 128);
    send(CMD_BWD);
    wait_sb_empty(200, "obst_bwd_done");
    repeat (12) @(negedge clk);
    check("obst_bwd_motor", int'(motor_dc), 8);
    check("obst_bwd_dir", int'(direction), 0);
    obst(1'b1);

    // Abort with OFF at motor 10
    push(0, 0, 128);
    push(0, 0, 132);
    push(0, 1, 132);
    for (int v = 1; v <= 10; v++) push(v, 1, 132);
    send(CMD_STOP); send(CMD_RIGHT); send(CMD_FWD); send(CMD_FWD);
    wait_sb_empty(200, "abort_ramp_done");
    push(0, 1, 128);
    send(CMD_OFF);
    $display("off_abort motor=%0d servo=%0d running=%0d", motor_dc, servo_dc, running);
    check("off_motor", int'(motor_dc), 0);
    check("off_servo", int'(servo_dc), 128);
    check("off_running", int'(running), 0);

    // Asynchronous reset mid-ramp (backward, steered)
    push(0, 1, 132);
    push(0, 0, 132);
    for (int v = 1; v <= 5; v++) push(v, 0, 132);
    send(CMD_ON); send(CMD_RIGHT); send(CMD_BWD); send(CMD_BWD);
    wait_sb_empty(200, "reset_ramp_done");
    #2 rst_n = 1'b0;
    #1;
    $display("async_reset motor=%0d dir=%0d servo=%0d running=%0d", motor_dc, direction, servo_dc, running);
    check("arst_motor", int'(motor_dc), 0);
    check("arst_dir", int'(direction), 1);
    check("arst_servo", int'(servo_dc), 128);
    check("arst_ctl", int'(ctl_valid), 0);
    check("arst_running", int'(running), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Watchdog on the short-timeout instance
    send_wd(CMD_ON); send_wd(CMD_FWD); send_wd(CMD_FWD);
    for (int k = 0; k < 20 && wd_motor_dc != 8'd16; k++) begin
      send_wd(CMD_RSVD);
      repeat (12) @(negedge clk);
    end
    check("wd_reach16", int'(wd_motor_dc), 16);
    send_wd(CMD_RSVD);
    n_first = 0; n_zero = 0; first_val = -1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (wd_motor_dc != 8'd16 && n_first == 0) begin
        n_first = n;
        first_val = int'(wd_motor_dc);
      end
      if (wd_motor_dc == 8'd0) begin
        n_zero = n;
        break;
      end
    end
    $display("watchdog first_change=%0d value=%0d zero_at=%0d", n_first, first_val, n_zero);
    check("wd_decel_start_window", int'(n_first >= 33 && n_first <= 36), 1);
    check("wd_first_value", first_val, 15);
    check("wd_decel_length", n_zero - n_first, 60);
    check("wd_dir", int'(wd_direction), 1);
    check("wd_running", int'(wd_running), 1);

    check("sb_final_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
